sha_hasher_core: RTL and testbench

- Iterative SHA-256 compression engine for the second 64-byte chunk of an 80-byte block header. The first chunk is precomputed off-block.
- Loads the midstate and header tail (merkle tail, time, target, nonce), runs 64 rounds at one round per clock, adds the initial digest, and compares the result against target.
- Sits between the work-distribution register file and the result FIFO of the miner.

---
 rtl/sha_hasher_core.sv | 177 +++++++++++++++++
 tb/tb_sha_hasher_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_hasher_core.sv
// Iterative SHA-256 compression of the second header chunk: one round per clock, then a target compare.
// Optional: define SHA_HASHER_NONCE_SWEEP_EN to keep retrying with nonce+1 after each miss.
module sha_hasher_core #(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         write_en,
  input  logic [255:0] digest_intial,
  input  logic [255:0] digest_in,
  input  logic [31:0]  merkle_in,
  input  logic [31:0]  time_in,
  input  logic [31:0]  target_in,
  input  logic [31:0]  nonce_in,
  output logic         valid_out,
  output logic [31:0]  time_out,
  output logic [31:0]  nonce_out
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t       state_q, state_d;
  logic [6:0]   rnd_cnt;
  logic [31:0]  wk    [8];   // working state a..h
  logic [31:0]  sched [16];  // sched[0] is W[t] of the current round
  logic [255:0] init_q;
  logic [31:0]  time_q, nonce_q, target_q;
  logic [255:0] final_hash;
  logic         hit, load, start;
  logic [255:0] ld_digest;
  logic [31:0]  ld_merkle, ld_time, ld_target, ld_nonce;
  logic [31:0]  t1, t2, w_next;

`ifdef SHA_HASHER_NONCE_SWEEP_EN
  logic [255:0] start_q;
  logic [31:0]  merkle_q;
  logic         reload;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++)
      final_hash[255-32*i -: 32] = init_q[255-32*i -: 32] + wk[i];
    hit = (final_hash[31:0] <= target_q);
  end

  // Round datapath: T1/T2 and the next schedule word W[t+16].
  always_comb begin
    t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
       + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[rnd_cnt[5:0]] + sched[0];
    t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
       + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    w_next = (rotr(sched[14], 17) ^ rotr(sched[14], 19) ^ (sched[14] >> 10)) + sched[9]
           + (rotr(sched[1], 7) ^ rotr(sched[1], 18) ^ (sched[1] >> 3)) + sched[0];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    load      = 1'b0;
    ld_digest = digest_in;
    ld_merkle = merkle_in;
    ld_time   = time_in;
    ld_target = target_in;
    ld_nonce  = nonce_in;
`ifdef SHA_HASHER_NONCE_SWEEP_EN
    reload    = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (write_en) begin
        state_d = ROUND;
        load    = 1'b1;
      end
      ROUND: if (rnd_cnt == 7'(ROUNDS - 1)) state_d = FINAL;
      FINAL: begin
        state_d = IDLE;
`ifdef SHA_HASHER_NONCE_SWEEP_EN
        if (!hit && nonce_q != 32'hFFFF_FFFF) begin
          state_d   = ROUND;
          reload    = 1'b1;
          ld_digest = start_q;
          ld_merkle = merkle_q;
          ld_time   = time_q;
          ld_target = target_q;
          ld_nonce  = nonce_q + 32'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef SHA_HASHER_NONCE_SWEEP_EN
    start = load | reload;
`else
    start = load;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the working and schedule arrays are flop banks, not RAM, so they take the reset too.
      for (int i = 0; i < 8; i++)  wk[i]    <= '0;
      for (int i = 0; i < 16; i++) sched[i] <= '0;
      rnd_cnt   <= '0;
      init_q    <= '0;
      time_q    <= '0;
      nonce_q   <= '0;
      target_q  <= '0;
      valid_out <= 1'b0;
      time_out  <= '0;
      nonce_out <= '0;
`ifdef SHA_HASHER_NONCE_SWEEP_EN
      start_q   <= '0;
      merkle_q  <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
      if (start) begin
        for (int i = 0; i < 8; i++) wk[i] <= ld_digest[255-32*i -: 32];
        sched[0]  <= ld_merkle;
        sched[1]  <= ld_time;
        sched[2]  <= ld_target;
        sched[3]  <= ld_nonce;
        sched[4]  <= 32'h8000_0000;
        for (int i = 5; i < 15; i++) sched[i] <= '0;
        sched[15] <= 32'h0000_0280;
        rnd_cnt   <= '0;
        time_q    <= ld_time;
        nonce_q   <= ld_nonce;
        target_q  <= ld_target;
        if (load) init_q <= digest_intial;
`ifdef SHA_HASHER_NONCE_SWEEP_EN
        if (load) begin
          start_q  <= digest_in;
          merkle_q <= merkle_in;
        end
`endif
      end else if (state_q == ROUND) begin
        wk[0] <= t1 + t2;
        wk[1] <= wk[0];
        wk[2] <= wk[1];
        wk[3] <= wk[2];
        wk[4] <= wk[3] + t1;
        wk[5] <= wk[4];
        wk[6] <= wk[5];
        wk[7] <= wk[6];
        for (int i = 0; i < 15; i++) sched[i] <= sched[i+1];
        sched[15] <= w_next;
        rnd_cnt   <= rnd_cnt + 7'd1;
      end
      if (state_q == FINAL && hit) begin
        valid_out <= 1'b1;
        time_out  <= time_q;
        nonce_out <= nonce_q;
      end
    end
  end

endmodule

// File: tb/tb_sha_hasher_core.sv
// Self-checking bench for sha_hasher_core: directed sequence with random jobs against a SHA-256 software model.
module tb_sha_hasher_core;

  typedef struct {
    logic [255:0] mid;
    logic [255:0] st;
    logic [31:0]  m, tm, tg, n;
  } job_t;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         CLK = 1'b0;
  logic         RST;
  logic         write_en;
  logic [255:0] digest_intial, digest_in;
  logic [31:0]  merkle_in, time_in, target_in, nonce_in;
  logic         valid_out;
  logic [31:0]  time_out, nonce_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_time = '0;
  logic [31:0] exp_nonce = '0;

  sha_hasher_core dut (
    .CLK(CLK), .RST(RST), .write_en(write_en),
    .digest_intial(digest_intial), .digest_in(digest_in),
    .merkle_in(merkle_in), .time_in(time_in), .target_in(target_in), .nonce_in(nonce_in),
    .valid_out(valid_out), .time_out(time_out), .nonce_out(nonce_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of the padded 16-byte header tail.
  function automatic logic [255:0] model(input job_t j);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] res;
    for (int i = 0; i < 64; i++) w[i] = '0;
    w[0] = j.m; w[1] = j.tm; w[2] = j.tg; w[3] = j.n;
    w[4] = 32'h8000_0000; w[15] = 32'd640;
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = j.st[255-32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[r] + w[r];
      x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = j.mid[255-32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    for (int i = 0; i < 8; i++) begin
      j.mid[32*i +: 32] = $urandom;
      j.st[32*i +: 32]  = $urandom;
    end
    j.m = $urandom; j.tm = $urandom; j.tg = $urandom; j.n = $urandom;
    return j;
  endfunction

  task automatic drive(input job_t j);
    digest_intial = j.mid; digest_in = j.st;
    merkle_in = j.m; time_in = j.tm; target_in = j.tg; nonce_in = j.n;
  endtask

  // Called at the falling edge after the job's load edge E0; returns at the falling edge after E65.
  task automatic finish_job(input job_t j, input string tag);
    logic [255:0] h;
    logic         h_hit;
    h     = model(j);
    h_hit = (h[31:0] <= j.tg);
    repeat (64) @(posedge CLK);
    @(negedge CLK);
    check({tag, " hash"}, dut.final_hash, h);
    check({tag, " valid before E65"}, {255'b0, valid_out}, 256'd0);
    @(posedge CLK);
    @(negedge CLK);
    if (h_hit) begin
      exp_time  = j.tm;
      exp_nonce = j.n;
    end
    check({tag, " valid at E65"}, {255'b0, valid_out}, {255'b0, h_hit});
    check({tag, " time_out"}, {224'b0, time_out}, {224'b0, exp_time});
    check({tag, " nonce_out"}, {224'b0, nonce_out}, {224'b0, exp_nonce});
  endtask

  task automatic run_job(input job_t j, input string tag);
    @(negedge CLK);
    drive(j);
    write_en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    write_en = 1'b0;
    drive(rand_job());
    finish_job(j, tag);
    @(posedge CLK);
    @(negedge CLK);
    check({tag, " valid after E66"}, {255'b0, valid_out}, 256'd0);
  endtask

  initial begin
    job_t ja, jb, jc;
    int   highs;

    // Reset state
    RST = 1'b0;
    write_en = 1'b0;
    drive(rand_job());
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset valid", {255'b0, valid_out}, 256'd0);
    check("reset time", {224'b0, time_out}, 256'd0);
    check("reset nonce", {224'b0, nonce_out}, 256'd0);
    RST = 1'b1;

    // Always-hit
    ja = rand_job();
    ja.tg = 32'hFFFF_FFFF; ja.tm = 32'h5A5A_0001; ja.n = 32'h1234_5678;
    run_job(ja, "always_hit");

    // Golden midstate
    ja = rand_job();
    ja.mid = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
    ja.st  = 256'hF7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776;
    ja.tg  = 32'hFFFF_FFFF;
    run_job(ja, "golden");

    // Miss: outputs must retain the previous hit
    ja = rand_job();
    ja.tg = 32'h0;
    for (int k = 0; k < 16 && model(ja)[31:0] == 32'h0; k++) ja.n = $urandom;
    run_job(ja, "miss");

    // Random targets, hit or miss decided by the model
    for (int k = 0; k < 4; k++) begin
      ja = rand_job();
      if (k == 1) ja.tg = 32'hFFFF_FFFE;
      if (k == 2) ja.tg = 32'h8000_0000;
      run_job(ja, "random");
    end

    // Busy ignore: write_en held high; jobs start at E0, E66, E132
    ja = rand_job(); ja.tg = 32'hFFFF_FFFF;
    jb = rand_job(); jb.tg = 32'hFFFF_FFFF;
    jc = rand_job(); jc.tg = 32'hFFFF_FFFF;
    @(negedge CLK);
    drive(ja);
    write_en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    drive(jb);
    finish_job(ja, "busy_a");
    @(posedge CLK);
    @(negedge CLK);
    check("busy_a valid after E66", {255'b0, valid_out}, 256'd0);
    drive(jc);
    finish_job(jb, "busy_b");
    @(posedge CLK);
    @(negedge CLK);
    write_en = 1'b0;
    drive(rand_job());
    finish_job(jc, "busy_c");
    @(posedge CLK);
    @(negedge CLK);
    check("busy_c valid after E66", {255'b0, valid_out}, 256'd0);

    // Reset abort at E30 of a hit job, outputs clear asynchronously
    ja = rand_job(); ja.tg = 32'hFFFF_FFFF;
    @(negedge CLK);
    drive(ja);
    write_en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    write_en = 1'b0;
    repeat (30) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    exp_time  = '0;
    exp_nonce = '0;
    check("async reset nonce", {224'b0, nonce_out}, 256'd0);
    check("async reset time", {224'b0, time_out}, 256'd0);
    @(negedge CLK);
    RST = 1'b1;
    highs = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK);
      if (valid_out) highs++;
    end
    check("abort no valid", 256'(highs), 256'd0);
    ja = rand_job(); ja.tg = 32'hFFFF_FFFF;
    run_job(ja, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
